// File: rtl/i2c_prom_pkg.sv
// i2c_prom_pkg: shared types and constants for the I2C PROM/command responder.
// Contents: FSM state enum, R/W and ACK bit encodings, default device address,
//           glitch-filter length used when I2C_RESP_GLITCH_FILT_EN is defined.
package i2c_prom_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_SUB,
      ST_SUB_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RBYTE,
      ST_RACK,
      ST_WAIT_STOP
   } state_t;

   localparam logic       I2C_WR_BIT       = 1'b0;
   localparam logic       I2C_RD_BIT       = 1'b1;
   localparam logic       I2C_ACK          = 1'b0;
   localparam logic       I2C_NACK         = 1'b1;
   localparam logic [6:0] I2C_DEF_DEV_ADDR = 7'h76;

   // Consecutive equal samples needed before the filtered line may change.
   localparam int         FILT_LEN         = 4;

endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: conditions one raw I2C line (2-FF sync, optional glitch filter
//                under I2C_RESP_GLITCH_FILT_EN) and emits registered level/edges.
// Ports: clk, rst (sync, active high), line_i (raw pin), level_o, rise_o, fall_o.
module i2c_line_cond
   import i2c_prom_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   // Sync flops reset high so an idle bus never looks like a falling edge.
   logic sync1_q, sync2_q;
   logic cond;
   logic lvl_q, rise_q, fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= line_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef I2C_RESP_GLITCH_FILT_EN
   localparam int CW = $clog2(FILT_LEN) + 1;

   logic          filt_q;
   logic [CW-1:0] cnt_q;

   // Count consecutive samples that disagree with the filtered value; any
   // agreeing sample restarts the count, so short pulses never get through.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b1;
         cnt_q  <= '0;
      end else if (sync2_q == filt_q) begin
         cnt_q  <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
         filt_q <= sync2_q;
         cnt_q  <= '0;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
      end
   end

   assign cond = filt_q;
`else
   assign cond = sync2_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q  <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         lvl_q  <= cond;
         rise_q <= cond & ~lvl_q;
         fall_q <= ~cond & lvl_q;
      end
   end

   assign level_o = lvl_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_prom_responder.sv
// i2c_prom_responder: I2C slave for the PROM/command protocol. Matches DEV_ADDR,
//   ACKs subaddress + write-data bytes, returns 16-bit words MSB first on reads.
// Ports: clk, rst (sync, active high), sio_c, sio_d (open drain), cmd_addr/cmd_vld,
//   wr_data/wr_vld, rd_data (sampled once per word), busy. Option: I2C_RESP_GLITCH_FILT_EN.
module i2c_prom_responder
   import i2c_prom_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = I2C_DEF_DEV_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sio_c,
   inout  wire         sio_d,
   output logic [7:0]  cmd_addr,
   output logic        cmd_vld,
   output logic [7:0]  wr_data,
   output logic        wr_vld,
   input  logic [15:0] rd_data,
   output logic        busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_cond u_scl (
      .clk     (clk),
      .rst     (rst),
      .line_i  (sio_c),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_line_cond u_sda (
      .clk     (clk),
      .rst     (rst),
      .line_i  (sio_d),
      .level_o (sda_lvl),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic [15:0] rsh_q, rsh_d;
   logic        byte2_q, byte2_d;
   logic        mack_q, mack_d;
   logic        sda_oe_q, sda_oe_d;
   logic [7:0]  cmd_addr_q, cmd_addr_d;
   logic        cmd_vld_q, cmd_vld_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        wr_vld_q, wr_vld_d;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sda_oe_q   <= 1'b0;
         cmd_addr_q <= '0;
         cmd_vld_q  <= 1'b0;
         wr_data_q  <= '0;
         wr_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sda_oe_q   <= sda_oe_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_vld_q  <= cmd_vld_d;
         wr_data_q  <= wr_data_d;
         wr_vld_q   <= wr_vld_d;
      end
   end

   // ---------------- next-state logic ----------------
   // STOP beats START beats SCL edges; byte boundaries act on the SCL falling
   // edge so SDA only ever changes while SCL is low.
   always_comb begin
      state_d = state_q;
      if (stop_det) begin
         state_d = ST_IDLE;
      end else if (start_det) begin
         state_d = ST_ADDR;
      end else if (scl_fall) begin
         case (state_q)
            ST_ADDR:      if (bit_cnt_q == 4'd8)
                             state_d = (sh_q[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
            ST_ADDR_ACK:  state_d = (sh_q[0] == I2C_RD_BIT) ? ST_RBYTE : ST_SUB;
            ST_SUB:       if (bit_cnt_q == 4'd8) state_d = ST_SUB_ACK;
            ST_SUB_ACK:   state_d = ST_WDATA;
            ST_WDATA:     if (bit_cnt_q == 4'd8) state_d = ST_WDATA_ACK;
            ST_WDATA_ACK: state_d = ST_WDATA;
            ST_RBYTE:     if (bit_cnt_q == 4'd8) state_d = ST_RACK;
            ST_RACK:      state_d = (mack_q == I2C_ACK) ? ST_RBYTE : ST_WAIT_STOP;
            default:      state_d = state_q;
         endcase
      end
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      rsh_d     = rsh_q;
      byte2_d   = byte2_q;
      mack_d    = mack_q;
      if (stop_det || start_det) begin
         bit_cnt_d = '0;
      end else if (scl_rise) begin
         if (state_q inside {ST_ADDR, ST_SUB, ST_WDATA}) begin
            sh_d      = {sh_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end else if (state_q == ST_RBYTE) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
         end else if (state_q == ST_RACK) begin
            mack_d = sda_lvl;
         end
      end else if (scl_fall) begin
         if (state_d != state_q) begin
            bit_cnt_d = '0;
         end
         // The 16-bit register shifts straight through both bytes; one extra
         // shift across the master-ACK slot lines up the low byte.
         if (state_q == ST_ADDR_ACK && state_d == ST_RBYTE) begin
            rsh_d   = rd_data;
            byte2_d = 1'b0;
         end else if (state_q == ST_RBYTE && state_d == ST_RBYTE) begin
            rsh_d = {rsh_q[14:0], 1'b0};
         end else if (state_q == ST_RACK && state_d == ST_RBYTE) begin
            if (byte2_q) begin
               rsh_d   = rd_data;
               byte2_d = 1'b0;
            end else begin
               rsh_d   = {rsh_q[14:0], 1'b0};
               byte2_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q <= '0;
         sh_q      <= '0;
         rsh_q     <= '0;
         byte2_q   <= 1'b0;
         mack_q    <= I2C_NACK;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         sh_q      <= sh_d;
         rsh_q     <= rsh_d;
         byte2_q   <= byte2_d;
         mack_q    <= mack_d;
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      sda_oe_d   = 1'b0;
      cmd_vld_d  = 1'b0;
      wr_vld_d   = 1'b0;
      cmd_addr_d = cmd_addr_q;
      wr_data_d  = wr_data_q;
      case (state_d)
         ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: sda_oe_d = 1'b1;
         ST_RBYTE:                              sda_oe_d = ~rsh_d[15];
         default:                               sda_oe_d = 1'b0;
      endcase
      if (state_q == ST_SUB && state_d == ST_SUB_ACK) begin
         cmd_vld_d  = 1'b1;
         cmd_addr_d = sh_q;
      end
      if (state_q == ST_WDATA && state_d == ST_WDATA_ACK) begin
         wr_vld_d  = 1'b1;
         wr_data_d = sh_q;
      end
   end

   // Open drain: pull low or release, never drive high.
   assign sio_d    = sda_oe_q ? 1'b0 : 1'bz;
   assign cmd_addr = cmd_addr_q;
   assign cmd_vld  = cmd_vld_q;
   assign wr_data  = wr_data_q;
   assign wr_vld   = wr_vld_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_prom_responder.sv
// tb_i2c_prom_responder: bit-banged I2C master driving i2c_prom_responder with
//   directed frames; cmd/wr pulses are checked by a scoreboard monitor, bus-level
//   ACKs and read bytes are checked as the master observes them.
module tb_i2c_prom_responder;

   localparam int Q = 10;   // clk cycles per quarter SCL period

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_scl = 1'b1;
   logic        m_sda_low = 1'b0;
   logic [15:0] rd_data = 16'h0000;
   wire         sio_d;
   logic [7:0]  cmd_addr, wr_data;
   logic        cmd_vld, wr_vld, busy;

   pullup (sio_d);
   assign sio_d = m_sda_low ? 1'b0 : 1'bz;

   i2c_prom_responder dut (
      .clk      (clk),
      .rst      (rst),
      .sio_c    (m_scl),
      .sio_d    (sio_d),
      .cmd_addr (cmd_addr),
      .cmd_vld  (cmd_vld),
      .wr_data  (wr_data),
      .wr_vld   (wr_vld),
      .rd_data  (rd_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cmd_pulses = 0;
   int wr_pulses = 0;
   int dut_low_cnt = 0;
   logic [7:0] exp_cmd_q[$];
   logic [7:0] exp_wr_q[$];
   logic [7:0] e_cmd, e_wr;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_vld) begin
            cmd_pulses++;
            checks++;
            if (exp_cmd_q.size() == 0) begin
               failures++;
               $display("FAIL cmd_vld_unexpected: got cmd_addr %h expected no pulse", cmd_addr);
            end else begin
               e_cmd = exp_cmd_q.pop_front();
               if (cmd_addr !== e_cmd) begin
                  failures++;
                  $display("FAIL cmd_addr: got %h expected %h", cmd_addr, e_cmd);
               end
            end
         end
         if (wr_vld) begin
            wr_pulses++;
            checks++;
            if (exp_wr_q.size() == 0) begin
               failures++;
               $display("FAIL wr_vld_unexpected: got wr_data %h expected no pulse", wr_data);
            end else begin
               e_wr = exp_wr_q.pop_front();
               if (wr_data !== e_wr) begin
                  failures++;
                  $display("FAIL wr_data: got %h expected %h", wr_data, e_wr);
               end
            end
         end
         if (sio_d === 1'b0 && !m_sda_low) dut_low_cnt++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; wq();
      m_scl = 1'b1;     wq();
      m_sda_low = 1'b1; wq();
      m_scl = 1'b0;     wq();
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; wq();
      m_scl = 1'b1;     wq();
      m_sda_low = 1'b0; wq();
   endtask

   task automatic mbit(input logic b, output logic rb);
      m_sda_low = ~b; wq();
      m_scl = 1'b1;   wq();
      rb = sio_d;     wq();
      m_scl = 1'b0;   wq();
   endtask

   task automatic wbyte(input logic [7:0] b, output logic ack);
      logic d;
      for (int i = 7; i >= 0; i--) mbit(b[i], d);
      mbit(1'b1, ack);
   endtask

   task automatic rbyte(input logic mack, output logic [7:0] b);
      logic d;
      for (int i = 7; i >= 0; i--) begin
         mbit(1'b1, d);
         b[i] = d;
      end
      mbit(mack, d);
   endtask

   logic       ack, d;
   logic [7:0] rb;
   int         low0;
   logic       seen;

   initial begin
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_addr", cmd_addr, 8'h00);
      chk("rst_wr_data", wr_data, 8'h00);
      chk("rst_cmd_vld", cmd_vld, 1'b0);
      chk("rst_wr_vld", wr_vld, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sda", sio_d, 1'b1);

`ifdef I2C_RESP_GLITCH_FILT_EN
      // 2-cycle SDA low with SCL high: filtered out, no START.
      seen = 1'b0;
      m_sda_low = 1'b1;
      repeat (2) @(negedge clk);
      m_sda_low = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("filt_glitch_no_start", seen, 1'b0);
      // 6-cycle SDA low: seen as START (then the release is a STOP).
      seen = 1'b0;
      m_sda_low = 1'b1;
      repeat (6) @(negedge clk);
      m_sda_low = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("filt_6cyc_start", seen, 1'b1);
      chk("filt_back_idle", busy, 1'b0);
`endif

      // Write frame
      i2c_start();
      chk("wr_busy_after_start", busy, 1'b1);
      wbyte(8'hEC, ack); chk("wr_ack_addr", ack, 1'b0);
      exp_cmd_q.push_back(8'h1E);
      wbyte(8'h1E, ack); chk("wr_ack_sub", ack, 1'b0);
      exp_wr_q.push_back(8'hA5);
      wbyte(8'hA5, ack); chk("wr_ack_data", ack, 1'b0);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("wr_busy_after_stop", busy, 1'b0);

      // Read sequence
      rd_data = 16'hBEEF;
      i2c_start();
      wbyte(8'hEC, ack); chk("rd_ack_waddr", ack, 1'b0);
      exp_cmd_q.push_back(8'hA2);
      wbyte(8'hA2, ack); chk("rd_ack_sub", ack, 1'b0);
      i2c_stop();
      i2c_start();
      wbyte(8'hED, ack); chk("rd_ack_raddr", ack, 1'b0);
      rbyte(1'b0, rb); chk("rd_byte1", rb, 8'hBE);
      rbyte(1'b1, rb); chk("rd_byte2", rb, 8'hEF);
      chk("rd_sda_released_after_nack", sio_d, 1'b1);
      i2c_stop();

      // Address mismatch
      low0 = dut_low_cnt;
      i2c_start();
      wbyte(8'hEE, ack); chk("mm_nack_addr", ack, 1'b1);
      wbyte(8'h00, ack); chk("mm_nack_data", ack, 1'b1);
      i2c_stop();
      chk("mm_sda_never_low", 16'(dut_low_cnt - low0), 16'd0);

      // Repeated START, wrap with relatch
      rd_data = 16'h1234;
      i2c_start();
      wbyte(8'hEC, ack); chk("sr_ack_waddr", ack, 1'b0);
      exp_cmd_q.push_back(8'hA4);
      wbyte(8'hA4, ack); chk("sr_ack_sub", ack, 1'b0);
      i2c_start();
      wbyte(8'hED, ack); chk("sr_ack_raddr", ack, 1'b0);
      rbyte(1'b0, rb); chk("sr_byte1", rb, 8'h12);
      rd_data = 16'h5678;
      rbyte(1'b0, rb); chk("sr_byte2_latched", rb, 8'h34);
      rbyte(1'b1, rb); chk("sr_wrap_relatch", rb, 8'h56);
      i2c_stop();

      // Abort mid data byte
      i2c_start();
      wbyte(8'hEC, ack); chk("ab_ack_addr", ack, 1'b0);
      exp_cmd_q.push_back(8'h10);
      wbyte(8'h10, ack); chk("ab_ack_sub", ack, 1'b0);
      mbit(1'b1, d); mbit(1'b0, d); mbit(1'b1, d); mbit(1'b0, d);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("ab_busy", busy, 1'b0);
      chk("ab_no_wr_vld", 16'(wr_pulses), 16'd1);

      // Reset mid-read
      rd_data = 16'h0000;
      i2c_start();
      wbyte(8'hED, ack); chk("rr_ack_raddr", ack, 1'b0);
      chk("rr_sda_driven_low", sio_d, 1'b0);
      chk("rr_busy", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rr_sda_released", sio_d, 1'b1);
      chk("rr_cmd_addr", cmd_addr, 8'h00);
      chk("rr_wr_data", wr_data, 8'h00);
      chk("rr_cmd_vld", cmd_vld, 1'b0);
      chk("rr_wr_vld", wr_vld, 1'b0);
      chk("rr_busy_reset", busy, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("rr_busy_end", busy, 1'b0);

      // Scoreboard drained, pulse totals
      chk("sb_cmd_left", 16'(exp_cmd_q.size()), 16'd0);
      chk("sb_wr_left", 16'(exp_wr_q.size()), 16'd0);
      chk("cmd_pulse_total", 16'(cmd_pulses), 16'd4);
      chk("wr_pulse_total", 16'(wr_pulses), 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
